// File: rtl/sparse_tok_pkg.sv
// sparse_tok_pkg: shared sparse-stream token format, token helpers and drop-unit FSM states
//   Token: bit 16 = control flag; data = {0, coord}; stop S_k = 0x10000 | k; done = 0x10100
package sparse_tok_pkg;
    localparam int TOKEN_W = 17;
    localparam logic [TOKEN_W-1:0] STOP_BASE = 17'h10000;
    localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

    typedef enum logic [1:0] {ST_OUTER, ST_INNER, ST_OSTOP, ST_IDONE} crd_state_e;

    function automatic logic is_done(input logic [TOKEN_W-1:0] t);
        return t == DONE_TOKEN;
    endfunction

    function automatic logic is_stop(input logic [TOKEN_W-1:0] t);
        return t[TOKEN_W-1] && t != DONE_TOKEN;
    endfunction

    function automatic logic [15:0] stop_lvl(input logic [TOKEN_W-1:0] t);
        return t[15:0];
    endfunction

    function automatic logic [TOKEN_W-1:0] mk_stop(input logic [15:0] k);
        return STOP_BASE | {1'b0, k};
    endfunction
endpackage

// File: rtl/crd_fifo2.sv
// crd_fifo2: 2-entry register FIFO; output is the registered head entry
//   rst     : sync active-high clear      en   : update enable
//   push/din: write when not full          pop  : drop head when not empty
//   dout    : head entry                   full/empty : occupancy flags
module crd_fifo2
    import sparse_tok_pkg::*;
#(
    parameter int W = TOKEN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wp_q, wp_d, rp_q, rp_d;
    logic [1:0]        cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d  = push ? !wp_q : wp_q;
        rp_d  = pop ? !rp_q : rp_q;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else if (en) begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rp_q];
    assign full  = cnt_q == 2'd2;
    assign empty = cnt_q == 2'd0;
endmodule

// File: rtl/crd_drop_unit.sv
// crd_drop_unit: drops outer coordinates whose intersected inner fiber is empty, merging their stops
//   clk, flush (sync active-high clear), clk_en (update enable), tile_en (gates all ready/valid)
//   coord_in_outer/_valid/_ready  : outer coordinate stream in
//   coord_in_inner/_valid/_ready  : inner stream in (from intersect_unit)
//   coord_out_outer/_valid/_ready : filtered outer stream out
//   coord_out_inner/_valid/_ready : filtered inner stream out
//   proto_err : sticky protocol error, only when CRD_DROP_PROTO_CHECK_EN is defined (else 0)
module crd_drop_unit
    import sparse_tok_pkg::*;
(
    input  logic               clk,
    input  logic               flush,
    input  logic               clk_en,
    input  logic               tile_en,
    input  logic [TOKEN_W-1:0] coord_in_outer,
    input  logic               coord_in_outer_valid,
    output logic               coord_in_outer_ready,
    input  logic [TOKEN_W-1:0] coord_in_inner,
    input  logic               coord_in_inner_valid,
    output logic               coord_in_inner_ready,
    output logic [TOKEN_W-1:0] coord_out_outer,
    output logic               coord_out_outer_valid,
    input  logic               coord_out_outer_ready,
    output logic [TOKEN_W-1:0] coord_out_inner,
    output logic               coord_out_inner_valid,
    input  logic               coord_out_inner_ready,
    output logic               proto_err
);
    crd_state_e         state_q, state_d;
    logic [15:0]        c_q, c_d, pend_q, pend_d;
    logic               has_data_q, has_data_d, pend_valid_q, pend_valid_d;
    logic               en, o_acc, i_acc, o_ctrl, i_ctrl, bad_o, bad_i;
    logic               outer_rdy, inner_rdy;
    logic               o_push, i_push, o_full, i_full, o_empty, i_empty;
    logic [TOKEN_W-1:0] o_din, i_din;
    logic [15:0]        i_lvl;

    assign en     = tile_en && clk_en && !flush;
    assign o_ctrl = coord_in_outer[TOKEN_W-1];
    assign i_ctrl = coord_in_inner[TOKEN_W-1];
    assign i_lvl  = stop_lvl(coord_in_inner);

    // Inner data waits while a stop is pending or the FIFOs it needs are full;
    // stops never push directly, so they are always accepted in INNER.
    always_comb begin
        outer_rdy = (state_q == ST_OUTER || state_q == ST_OSTOP) && !o_full;
        inner_rdy = state_q == ST_INNER ? i_ctrl || (!pend_valid_q && !i_full && (has_data_q || !o_full)) :
                    state_q == ST_IDONE ? !pend_valid_q && !i_full : 1'b0;
    end

    assign coord_in_outer_ready = en && outer_rdy;
    assign coord_in_inner_ready = en && inner_rdy;
    assign o_acc = coord_in_outer_valid && coord_in_outer_ready;
    assign i_acc = coord_in_inner_valid && coord_in_inner_ready;

`ifdef CRD_DROP_PROTO_CHECK_EN
    logic [15:0] ostop_lvl_q, ostop_lvl_d;
    logic        err_q, err_d;
    assign bad_o = state_q == ST_OSTOP && coord_in_outer != mk_stop(ostop_lvl_q);
    assign bad_i = (state_q == ST_INNER && is_done(coord_in_inner)) ||
                   (state_q == ST_IDONE && !is_done(coord_in_inner));
    assign ostop_lvl_d = (state_q == ST_INNER && i_acc && i_ctrl) ? i_lvl - 16'd1 : ostop_lvl_q;
    assign err_d = err_q || (o_acc && bad_o) || (i_acc && bad_i);
    always_ff @(posedge clk) begin
        if (flush) begin
            ostop_lvl_q <= '0;
            err_q       <= 1'b0;
        end else if (clk_en) begin
            ostop_lvl_q <= ostop_lvl_d;
            err_q       <= err_d;
        end
    end
    assign proto_err = err_q;
`else
    assign bad_o     = 1'b0;
    assign bad_i     = 1'b0;
    assign proto_err = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        c_d          = c_q;
        has_data_d   = has_data_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        o_push       = 1'b0;
        o_din        = coord_in_outer;
        i_push       = 1'b0;
        i_din        = coord_in_inner;
        case (state_q)
            ST_OUTER: begin
                if (o_acc && !o_ctrl) begin
                    c_d        = coord_in_outer[15:0];
                    has_data_d = 1'b0;
                    state_d    = ST_INNER;
                end else if (o_acc && is_done(coord_in_outer)) begin
                    o_push  = 1'b1;
                    state_d = ST_IDONE;
                end
            end
            ST_INNER: begin
                if (en && coord_in_inner_valid && pend_valid_q && !i_ctrl && !i_full) begin
                    // flush the held stop ahead of the data token, which stays put
                    i_push       = 1'b1;
                    i_din        = mk_stop(pend_q);
                    pend_valid_d = 1'b0;
                end else if (i_acc && !bad_i && !i_ctrl) begin
                    i_push     = 1'b1;
                    o_push     = !has_data_q;
                    o_din      = {1'b0, c_q};
                    has_data_d = 1'b1;
                end else if (i_acc && !bad_i) begin
                    // non-empty fiber: take S_k; empty fiber: keep max level, S_0 alone is dropped
                    pend_d       = (has_data_q || !pend_valid_q || i_lvl > pend_q) ? i_lvl : pend_q;
                    pend_valid_d = pend_valid_q || has_data_q || i_lvl != 16'd0;
                    state_d      = i_lvl == 16'd0 ? ST_OUTER : ST_OSTOP;
                end
            end
            ST_OSTOP: begin
                if (o_acc && !bad_o) begin
                    o_push  = 1'b1;
                    state_d = ST_OUTER;
                end
            end
            ST_IDONE: begin
                if (en && pend_valid_q && !i_full) begin
                    i_push       = 1'b1;
                    i_din        = mk_stop(pend_q);
                    pend_valid_d = 1'b0;
                end else if (i_acc && !bad_i) begin
                    i_push  = 1'b1;
                    state_d = ST_OUTER;
                end
            end
            default: state_d = ST_OUTER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            state_q      <= ST_OUTER;
            c_q          <= '0;
            has_data_q   <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            c_q          <= c_d;
            has_data_q   <= has_data_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    crd_fifo2 u_fifo_outer (
        .clk  (clk),
        .rst  (flush),
        .en   (clk_en),
        .push (o_push),
        .din  (o_din),
        .pop  (coord_out_outer_valid && coord_out_outer_ready),
        .dout (coord_out_outer),
        .full (o_full),
        .empty(o_empty)
    );

    crd_fifo2 u_fifo_inner (
        .clk  (clk),
        .rst  (flush),
        .en   (clk_en),
        .push (i_push),
        .din  (i_din),
        .pop  (coord_out_inner_valid && coord_out_inner_ready),
        .dout (coord_out_inner),
        .full (i_full),
        .empty(i_empty)
    );

    assign coord_out_outer_valid = en && !o_empty;
    assign coord_out_inner_valid = en && !i_empty;
endmodule

// File: tb/tb_crd_drop_unit.sv
// tb_crd_drop_unit: table-driven stream checks for crd_drop_unit plus backpressure, flush and protocol sequences
module tb_crd_drop_unit;
    localparam logic [16:0] S0 = 17'h10000;
    localparam logic [16:0] S1 = 17'h10001;
    localparam logic [16:0] D  = 17'h10100;
    localparam int OI = 0, II = 1, EO = 2, EI = 3;

    typedef struct {
        int          tc;
        int          k;
        logic [16:0] t;
    } row_t;

    logic        clk = 1'b0;
    logic        flush, clk_en, tile_en;
    logic [16:0] coord_in_outer, coord_in_inner, coord_out_outer, coord_out_inner;
    logic        coord_in_outer_valid, coord_in_outer_ready, coord_in_inner_valid, coord_in_inner_ready;
    logic        coord_out_outer_valid, coord_out_outer_ready, coord_out_inner_valid, coord_out_inner_ready;
    logic        proto_err;

    int          n_chk = 0, n_err = 0;
    logic [16:0] qoi[$], qii[$], eo[$], ei[$], got_o[$], got_i[$];
    row_t        rows[$];

    always #5 clk = ~clk;

    crd_drop_unit dut (
        .clk                  (clk),
        .flush                (flush),
        .clk_en               (clk_en),
        .tile_en              (tile_en),
        .coord_in_outer       (coord_in_outer),
        .coord_in_outer_valid (coord_in_outer_valid),
        .coord_in_outer_ready (coord_in_outer_ready),
        .coord_in_inner       (coord_in_inner),
        .coord_in_inner_valid (coord_in_inner_valid),
        .coord_in_inner_ready (coord_in_inner_ready),
        .coord_out_outer      (coord_out_outer),
        .coord_out_outer_valid(coord_out_outer_valid),
        .coord_out_outer_ready(coord_out_outer_ready),
        .coord_out_inner      (coord_out_inner),
        .coord_out_inner_valid(coord_out_inner_valid),
        .coord_out_inner_ready(coord_out_inner_ready),
        .proto_err            (proto_err)
    );

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input int tc);
        qoi.delete(); qii.delete(); eo.delete(); ei.delete();
        foreach (rows[i]) if (rows[i].tc == tc) begin
            if (rows[i].k == OI) qoi.push_back(rows[i].t);
            if (rows[i].k == II) qii.push_back(rows[i].t);
            if (rows[i].k == EO) eo.push_back(rows[i].t);
            if (rows[i].k == EI) ei.push_back(rows[i].t);
        end
    endtask

    task automatic run_stream(input int stall, input int flush_at, input int max_cyc, input bit must_end);
        int acc = 0, acc_i = 0, idle = 0;
        got_o.delete(); got_i.delete();
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (flush_at >= 0 && acc >= flush_at) begin
                flush = 1'b1;
                coord_in_outer_valid = 1'b0;
                coord_in_inner_valid = 1'b0;
                #1;
                check("flush_cycle_ready", {15'b0, coord_in_outer_ready, coord_in_inner_ready}, 17'h0);
                check("flush_cycle_valid", {15'b0, coord_out_outer_valid, coord_out_inner_valid}, 17'h0);
                @(negedge clk);
                flush = 1'b0;
                #1;
                check("after_flush_valid", {15'b0, coord_out_outer_valid, coord_out_inner_valid}, 17'h0);
                qoi.delete(); qii.delete();
                return;
            end
            coord_in_outer_valid  = qoi.size() > 0;
            coord_in_outer        = qoi.size() > 0 ? qoi[0] : 17'h0;
            coord_in_inner_valid  = qii.size() > 0;
            coord_in_inner        = qii.size() > 0 ? qii[0] : 17'h0;
            coord_out_outer_ready = 1'b1;
            coord_out_inner_ready = cyc >= stall;
            #1;
            if (stall > 0 && cyc == stall - 1) begin
                check("stall_in_inner_ready", {16'b0, coord_in_inner_ready}, 17'h0);
                check("stall_inner_accepted", 17'(acc_i), 17'd3);
                check("stall_out_inner_valid", {16'b0, coord_out_inner_valid}, 17'h1);
            end
            if (coord_in_outer_valid && coord_in_outer_ready) begin
                void'(qoi.pop_front());
                acc++;
            end
            if (coord_in_inner_valid && coord_in_inner_ready) begin
                void'(qii.pop_front());
                acc++;
                acc_i++;
            end
            if (coord_out_outer_valid && coord_out_outer_ready) got_o.push_back(coord_out_outer);
            if (coord_out_inner_valid && coord_out_inner_ready) got_i.push_back(coord_out_inner);
            idle = (qoi.size() == 0 && qii.size() == 0 && got_o.size() >= eo.size() &&
                    got_i.size() >= ei.size()) ? idle + 1 : 0;
            if (must_end && idle == 4) return;
        end
        if (must_end) begin
            n_chk++;
            n_err++;
            $display("FAIL timeout: got %0d/%0d outer %0d/%0d inner tokens", got_o.size(), eo.size(),
                     got_i.size(), ei.size());
        end
    endtask

    task automatic cmp_streams(input string name);
        check($sformatf("%s_outer_len", name), 17'(got_o.size()), 17'(eo.size()));
        foreach (eo[i]) check($sformatf("%s_outer[%0d]", name, i), i < got_o.size() ? got_o[i] : 17'h1ffff, eo[i]);
        check($sformatf("%s_inner_len", name), 17'(got_i.size()), 17'(ei.size()));
        foreach (ei[i]) check($sformatf("%s_inner[%0d]", name, i), i < got_i.size() ? got_i[i] : 17'h1ffff, ei[i]);
    endtask

    initial begin
        rows = '{
            '{0, OI, 17'h0}, '{0, OI, 17'h1}, '{0, OI, 17'h2}, '{0, OI, S0}, '{0, OI, D},
            '{0, II, 17'h5}, '{0, II, S0}, '{0, II, S0}, '{0, II, 17'h7}, '{0, II, 17'h8}, '{0, II, S1}, '{0, II, D},
            '{0, EO, 17'h0}, '{0, EO, 17'h2}, '{0, EO, S0}, '{0, EO, D},
            '{0, EI, 17'h5}, '{0, EI, S0}, '{0, EI, 17'h7}, '{0, EI, 17'h8}, '{0, EI, S1}, '{0, EI, D},
            '{1, OI, 17'h3}, '{1, OI, 17'h4}, '{1, OI, S0}, '{1, OI, D},
            '{1, II, 17'h9}, '{1, II, S0}, '{1, II, S1}, '{1, II, D},
            '{1, EO, 17'h3}, '{1, EO, S0}, '{1, EO, D},
            '{1, EI, 17'h9}, '{1, EI, S1}, '{1, EI, D},
            '{2, OI, 17'h1}, '{2, OI, S0}, '{2, OI, D},
            '{2, II, S1}, '{2, II, D},
            '{2, EO, S0}, '{2, EO, D},
            '{2, EI, S1}, '{2, EI, D}
        };
        flush = 1'b1; clk_en = 1'b1; tile_en = 1'b1;
        coord_in_outer = 17'h0; coord_in_inner = 17'h0;
        coord_in_outer_valid = 1'b1; coord_in_inner_valid = 1'b1;
        coord_out_outer_ready = 1'b1; coord_out_inner_ready = 1'b1;
        @(negedge clk); #1;
        check("reset_in_ready", {15'b0, coord_in_outer_ready, coord_in_inner_ready}, 17'h0);
        check("reset_out_valid", {15'b0, coord_out_outer_valid, coord_out_inner_valid}, 17'h0);
        @(negedge clk);
        flush = 1'b0;
        coord_in_outer_valid = 1'b0; coord_in_inner_valid = 1'b0;
        #1;
        check("idle_in_ready", {15'b0, coord_in_outer_ready, coord_in_inner_ready}, 17'h2);
        check("idle_out_valid", {15'b0, coord_out_outer_valid, coord_out_inner_valid}, 17'h0);
        check("idle_proto_err", {16'b0, proto_err}, 17'h0);
        tile_en = 1'b0;
        coord_in_outer_valid = 1'b1;
        #1;
        check("tile_off_ready", {15'b0, coord_in_outer_ready, coord_in_inner_ready}, 17'h0);
        @(negedge clk);
        tile_en = 1'b1;
        coord_in_outer_valid = 1'b0;

        for (int tc = 0; tc < 3; tc++) begin
            load(tc);
            run_stream(0, -1, 200, 1'b1);
            cmp_streams($sformatf("case%0d", tc + 1));
        end

        load(0);
        run_stream(10, -1, 200, 1'b1);
        cmp_streams("backpressure");

        load(0);
        run_stream(0, 3, 200, 1'b1);
        load(0);
        run_stream(0, -1, 200, 1'b1);
        cmp_streams("after_flush");

        qoi = '{17'h0, D};
        qii = '{17'h5, S1, D};
        eo.delete(); ei.delete();
        run_stream(0, -1, 15, 1'b0);
`ifdef CRD_DROP_PROTO_CHECK_EN
        eo = '{17'h0};
        ei = '{17'h5};
        cmp_streams("proto");
        check("proto_err_set", {16'b0, proto_err}, 17'h1);
        repeat (5) @(negedge clk);
        #1;
        check("proto_err_sticky", {16'b0, proto_err}, 17'h1);
`else
        eo = '{17'h0, D};
        ei = '{17'h5};
        cmp_streams("proto");
        check("proto_err_tied", {16'b0, proto_err}, 17'h0);
`endif
        @(negedge clk);
        flush = 1'b1;
        coord_in_outer_valid = 1'b0;
        coord_in_inner_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("proto_err_cleared", {16'b0, proto_err}, 17'h0);
        load(1);
        run_stream(0, -1, 200, 1'b1);
        cmp_streams("case2_after_proto");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
